// File: rtl/qam_pkg.sv
// Shared definitions for the BPSK / QPSK / 16-QAM constellation mapper.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package qam_pkg;

    // Constellation selection. The raw 2-bit code 3 is reserved and decodes to BPSK.
    typedef enum logic [1:0] {
        MODE_BPSK  = 2'd0,
        MODE_QPSK  = 2'd1,
        MODE_16QAM = 2'd2
    } mode_e;

    // Per-axis 16-QAM level indices; the output is index x unit step.
    localparam int LVL_M3 = -3;
    localparam int LVL_M1 = -1;
    localparam int LVL_P1 = 1;
    localparam int LVL_P3 = 3;

    // Bits collected per symbol for a given constellation.
    function automatic logic [2:0] bits_per_sym(input mode_e mode);
        logic [2:0] n;
        case (mode)
            MODE_QPSK:  n = 3'd2;
            MODE_16QAM: n = 3'd4;
            default:    n = 3'd1;
        endcase
        return n;
    endfunction

    // Raw mode input to a legal mode; reserved code falls back to BPSK.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        mode_e m;
        if (raw == 2'd3) m = MODE_BPSK;
        else             m = mode_e'(raw);
        return m;
    endfunction

endpackage

// File: rtl/qam_axis_map.sv
// Maps one axis bit pair to a signed constellation level (purpose).
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
// Ports: mode_i selects constellation; pair_i[1] is the earlier bit of the pair
//        (pair_i[0] ignored for BPSK/QPSK); level_o is the signed W-bit level.
// Build option: QAM_GRAY_EN selects Gray per-axis 16-QAM coding; otherwise natural binary.
module qam_axis_map
    import qam_pkg::*;
#(
    parameter int W      = 11,
    parameter int AMP_B  = 8,
    parameter int AMP_Q  = 6,
    parameter int AMP_16 = 3
) (
    input  mode_e                mode_i,
    input  logic [1:0]           pair_i,
    output logic signed [W-1:0]  level_o
);

    localparam logic signed [W-1:0] L_PB = W'(AMP_B);
    localparam logic signed [W-1:0] L_NB = W'(-AMP_B);
    localparam logic signed [W-1:0] L_PQ = W'(AMP_Q);
    localparam logic signed [W-1:0] L_NQ = W'(-AMP_Q);
    localparam logic signed [W-1:0] L_M3 = W'(LVL_M3 * AMP_16);
    localparam logic signed [W-1:0] L_M1 = W'(LVL_M1 * AMP_16);
    localparam logic signed [W-1:0] L_P1 = W'(LVL_P1 * AMP_16);
    localparam logic signed [W-1:0] L_P3 = W'(LVL_P3 * AMP_16);

    always_comb begin
        level_o = '0;
        case (mode_i)
            MODE_QPSK: level_o = pair_i[1] ? L_PQ : L_NQ;
            MODE_16QAM: begin
`ifdef QAM_GRAY_EN
                // Gray order: adjacent levels differ in one bit.
                case (pair_i)
                    2'b00:   level_o = L_M3;
                    2'b01:   level_o = L_M1;
                    2'b11:   level_o = L_P1;
                    default: level_o = L_P3;
                endcase
`else
                case (pair_i)
                    2'b00:   level_o = L_M3;
                    2'b01:   level_o = L_M1;
                    2'b10:   level_o = L_P1;
                    default: level_o = L_P3;
                endcase
`endif
            end
            default: level_o = pair_i[1] ? L_PB : L_NB;
        endcase
    end

endmodule

// File: rtl/qam_mapper.sv
// Collects 1/2/4 serial bits per symbol and emits one registered BPSK/QPSK/16-QAM I/Q sample.
// Latency: valid_x rises one cycle after the valid_i cycle carrying the final bit of a symbol.
// Backpressure: none; the downstream buffer must accept every valid_x strobe, input gaps are free.
// Ports: CLK, RST (async active-low); valid_i/data_i serial bits (b0 first); mode_i constellation
//        (sampled at symbol start); clr_i discards a partial symbol; valid_x/xr/xi output sample;
//        busy high while a partial symbol is held.
// Build option: QAM_GRAY_EN selects Gray per-axis 16-QAM coding (see qam_axis_map).
module qam_mapper
    import qam_pkg::*;
#(
    parameter int W      = 11,
    parameter int AMP_B  = 8,
    parameter int AMP_Q  = 6,
    parameter int AMP_16 = 3
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 valid_i,
    input  logic                 data_i,
    input  logic [1:0]           mode_i,
    input  logic                 clr_i,
    output logic                 valid_x,
    output logic signed [W-1:0]  xr,
    output logic signed [W-1:0]  xi,
    output logic                 busy
);

    localparam int MAX_POS = (2 ** (W - 1)) - 1;

    if ((3 * AMP_16 > MAX_POS) || (AMP_Q > MAX_POS) || (AMP_B > MAX_POS)) begin : g_amp_range_err
        $fatal(1, "qam_mapper: amplitude parameters exceed signed range of W");
    end

    logic [1:0]          cnt_q,  cnt_d;
    logic [2:0]          sr_q,   sr_d;
    mode_e               mode_q, mode_d;
    logic                vld_q,  vld_d;
    logic signed [W-1:0] xr_q,   xr_d;
    logic signed [W-1:0] xi_q,   xi_d;
    logic                busy_q, busy_d;

    mode_e               mode_eff;
    logic [2:0]          nbits;
    logic [3:0]          cur;
    logic                last_bit;
    logic [1:0]          i_pair, q_pair;
    logic signed [W-1:0] i_lvl,  q_lvl;

    // At a symbol start the live mode input applies, so a 1-bit BPSK symbol
    // can complete on the same cycle its mode is sampled.
    always_comb begin
        mode_eff = (cnt_q == 2'd0) ? decode_mode(mode_i) : mode_q;
        nbits    = bits_per_sym(mode_eff);
        // Earlier bits sit higher: after N bits, b0 is cur[N-1].
        cur      = {sr_q, data_i};
        last_bit = ({1'b0, cnt_q} == (nbits - 3'd1));
    end

    always_comb begin
        i_pair = '0;
        q_pair = '0;
        case (mode_eff)
            MODE_QPSK: begin
                i_pair = {cur[1], 1'b0};
                q_pair = {cur[0], 1'b0};
            end
            MODE_16QAM: begin
                i_pair = cur[3:2];
                q_pair = cur[1:0];
            end
            default: i_pair = {cur[0], 1'b0};
        endcase
    end

    qam_axis_map #(.W(W), .AMP_B(AMP_B), .AMP_Q(AMP_Q), .AMP_16(AMP_16)) u_map_i (
        .mode_i  (mode_eff),
        .pair_i  (i_pair),
        .level_o (i_lvl)
    );

    qam_axis_map #(.W(W), .AMP_B(AMP_B), .AMP_Q(AMP_Q), .AMP_16(AMP_16)) u_map_q (
        .mode_i  (mode_eff),
        .pair_i  (q_pair),
        .level_o (q_lvl)
    );

    always_comb begin
        cnt_d  = cnt_q;
        sr_d   = sr_q;
        mode_d = mode_q;
        vld_d  = 1'b0;
        xr_d   = xr_q;
        xi_d   = xi_q;
        if (clr_i) begin
            // Discard wins over a same-cycle bit; outputs hold.
            cnt_d = '0;
            sr_d  = '0;
        end else if (valid_i) begin
            mode_d = mode_eff;
            if (last_bit) begin
                cnt_d = '0;
                sr_d  = '0;
                vld_d = 1'b1;
                xr_d  = i_lvl;
                xi_d  = (mode_eff == MODE_BPSK) ? '0 : q_lvl;
            end else begin
                cnt_d = cnt_q + 2'd1;
                sr_d  = cur[2:0];
            end
        end
        busy_d = (cnt_d != 2'd0);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q  <= '0;
            sr_q   <= '0;
            mode_q <= MODE_BPSK;
            vld_q  <= 1'b0;
            xr_q   <= '0;
            xi_q   <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sr_q   <= sr_d;
            mode_q <= mode_d;
            vld_q  <= vld_d;
            xr_q   <= xr_d;
            xi_q   <= xi_d;
            busy_q <= busy_d;
        end
    end

    assign valid_x = vld_q;
    assign xr      = xr_q;
    assign xi      = xi_q;
    assign busy    = busy_q;

endmodule
